// File: rtl/seg_pkg.sv
// seg_pkg: active-low 7-segment encodings ({g,f,e,d,c,b,a}) and width helper for the scan controller.
package seg_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] CODE_DASH = 4'hA;

  // Never returns less than 1 so single-value counters still get a real bit.
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: 4-bit digit code plus decimal-point flag to an active-low {dp,g..a} pattern.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);
  logic [6:0] seg;
  always_comb begin
    case (code_i)
      4'h0:      seg = SEG_0;
      4'h1:      seg = SEG_1;
      4'h2:      seg = SEG_2;
      4'h3:      seg = SEG_3;
      4'h4:      seg = SEG_4;
      4'h5:      seg = SEG_5;
      4'h6:      seg = SEG_6;
      4'h7:      seg = SEG_7;
      4'h8:      seg = SEG_8;
      4'h9:      seg = SEG_9;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
  end
  assign seg_o = {~dp_i, seg};
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode 7-segment scanner with blanking, PWM
// brightness, blink and a per-frame snapshot of the display data.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  i_clk,
  input  logic                  r_rst_n,
  input  logic                  i_enable,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blink_mask,
  input  logic [3:0]            i_bright,
  output logic [DIGITS-1:0]     o_seg_control,
  output logic [7:0]            o_seg_display,
  output logic                  o_frame_start
);
  localparam int SW = clog2(SCAN_DIV);
  localparam int DW = clog2(DIGITS);
  localparam int BW = clog2(BLINK_FRAMES);

  logic [SW-1:0]       slot_q, slot_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [BW-1:0]       blink_frm_q, blink_frm_d;
  logic                phase_q, phase_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dp_q, dp_d, mask_q, mask_d;
  logic [3:0]          bright_q, bright_d, pwm;
  logic [DIGITS-1:0]   ctrl_q, ctrl_d;
  logic [7:0]          disp_q, disp_d, seg;
  logic                fs_q, fs_d;
  logic                slot_wrap, frame_wrap, blink_wrap, dark, lit;

  seg_decoder u_dec (
    .code_i (data_q[{dig_q, 2'b00} +: 4]),
    .dp_i   (dp_q[dig_q]),
    .seg_o  (seg)
  );

  always_comb begin
    slot_wrap   = slot_q == SW'(SCAN_DIV - 1);
    frame_wrap  = slot_wrap && dig_q == DW'(DIGITS - 1);
    blink_wrap  = frame_wrap && blink_frm_q == BW'(BLINK_FRAMES - 1);
    slot_d      = slot_wrap ? '0 : slot_q + 1'b1;
    dig_d       = slot_wrap ? (dig_q == DW'(DIGITS - 1) ? '0 : dig_q + 1'b1) : dig_q;
    blink_frm_d = frame_wrap ? (blink_wrap ? '0 : blink_frm_q + 1'b1) : blink_frm_q;
    phase_d     = phase_q ^ blink_wrap;
    data_d      = frame_wrap ? i_data : data_q;
    dp_d        = frame_wrap ? i_dp : dp_q;
    mask_d      = frame_wrap ? i_blink_mask : mask_q;
    // Brightness is taken live in a slot's first cycle so that cycle is never stale.
    bright_d    = slot_q == '0 ? i_bright : bright_q;
    pwm         = 4'(slot_q - SW'(BLANK_CYCLES));
    dark        = !i_enable || (phase_q && mask_q[dig_q]);
    lit         = !dark && slot_q >= SW'(BLANK_CYCLES) && pwm < bright_d;
    ctrl_d      = lit ? ~(DIGITS'(1) << (DW'(DIGITS - 1) - dig_q)) : '1;
    disp_d      = dark ? 8'hFF : seg;
    fs_d        = slot_q == '0 && dig_q == '0;
  end

  always_ff @(posedge i_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      slot_q      <= '0;
      dig_q       <= '0;
      blink_frm_q <= '0;
      phase_q     <= 1'b0;
      data_q      <= '0;
      dp_q        <= '0;
      mask_q      <= '0;
      bright_q    <= '0;
      ctrl_q      <= '1;
      disp_q      <= 8'hFF;
      fs_q        <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      dig_q       <= dig_d;
      blink_frm_q <= blink_frm_d;
      phase_q     <= phase_d;
      data_q      <= data_d;
      dp_q        <= dp_d;
      mask_q      <= mask_d;
      bright_q    <= bright_d;
      ctrl_q      <= ctrl_d;
      disp_q      <= disp_d;
      fs_q        <= fs_d;
    end
  end

  assign o_seg_control = ctrl_q;
  assign o_seg_display = disp_q;
  assign o_frame_start = fs_q;
endmodule
